// File: rtl/pkt_rr_arbiter.sv
// Round-robin packet arbiter: N srdy/drdy inputs share one registered output.
// The grant is held from the first beat of a packet until its end-of-packet beat.
module pkt_rr_arbiter #(
  parameter int INPUTS = 8,
  parameter int WIDTH  = 16,
  parameter int GW     = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [INPUTS-1:0]       c_srdy,
  output logic [INPUTS-1:0]       c_drdy,
  input  logic [INPUTS*WIDTH-1:0] c_data,
  input  logic [INPUTS-1:0]       c_eop,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [WIDTH-1:0]        p_data,
  output logic                    p_eop,
  output logic [GW-1:0]           p_grant,
  output logic                    locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     last_q, last_d;
  logic              p_srdy_q, p_srdy_d;
  logic [WIDTH-1:0]  p_data_q, p_data_d;
  logic              p_eop_q, p_eop_d;
  logic [GW-1:0]     p_grant_q, p_grant_d;

  logic              ld;
  logic              xfer;
  logic              found;
  logic [GW-1:0]     scan_sel;
  logic [GW-1:0]     src;
  int                scan_idx;

  assign ld = !p_srdy_q || p_drdy;

  // First requester after last_q, wrapping from INPUTS-1 back to 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    scan_sel = '0;
    scan_idx = 0;
    for (int k = 1; k <= INPUTS; k++) begin
      scan_idx = (int'(last_q) + k) % INPUTS;
      if (!found && c_srdy[scan_idx]) begin
        found    = 1'b1;
        scan_sel = GW'(scan_idx);
      end
    end
  end

  // Gated by reset so ready drops the moment reset asserts, not at the next edge.
  always_comb begin
    c_drdy = '0;
    if (reset) begin
      if (state_q == LOCKED) begin
        c_drdy[gnt_q] = ld;
      end else if (enable && ld && found) begin
        c_drdy[scan_sel] = 1'b1;
      end
    end
  end

  assign src  = (state_q == LOCKED) ? gnt_q : scan_sel;
  assign xfer = |(c_srdy & c_drdy);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    p_srdy_d  = p_srdy_q;
    p_data_d  = p_data_q;
    p_eop_d   = p_eop_q;
    p_grant_d = p_grant_q;
    if (xfer) begin
      p_srdy_d  = 1'b1;
      p_data_d  = c_data[int'(src)*WIDTH +: WIDTH];
      p_eop_d   = c_eop[src];
      p_grant_d = src;
      if (c_eop[src]) begin
        state_d = IDLE;
        last_d  = src;
      end else begin
        state_d = LOCKED;
        gnt_d   = src;
      end
    end else if (p_drdy) begin
      p_srdy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= GW'(INPUTS - 1);
      p_srdy_q  <= 1'b0;
      p_data_q  <= '0;
      p_eop_q   <= 1'b0;
      p_grant_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      p_srdy_q  <= p_srdy_d;
      p_data_q  <= p_data_d;
      p_eop_q   <= p_eop_d;
      p_grant_q <= p_grant_d;
    end
  end

  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;
  assign p_eop   = p_eop_q;
  assign p_grant = p_grant_q;
  assign locked  = (state_q == LOCKED);

  a_drdy_onehot : assert property (
    @(posedge clock) disable iff (!reset) $onehot0(c_drdy));

  a_out_stable : assert property (
    @(posedge clock) disable iff (!reset)
    (p_srdy && !p_drdy) |=> ($stable(p_data) && $stable(p_eop) && $stable(p_grant)));

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter: packet sources, a behavioural arbiter model and an
// in-order payload scoreboard, exercised by one task per scenario.
module tb_pkt_rr_arbiter;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int GW = 3;

  logic           clock;
  logic           reset;
  logic           enable;
  logic [N-1:0]   c_srdy;
  logic [N-1:0]   c_drdy;
  logic [N*W-1:0] c_data;
  logic [N-1:0]   c_eop;
  logic           p_srdy;
  logic           p_drdy;
  logic [W-1:0]   p_data;
  logic           p_eop;
  logic [GW-1:0]  p_grant;
  logic           locked;

  pkt_rr_arbiter #(.INPUTS(N), .WIDTH(W), .GW(GW)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .c_eop  (c_eop),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .p_eop  (p_eop),
    .p_grant(p_grant),
    .locked (locked)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Sources: beats left in the current packet and next sequence number.
  int src_left[N];
  int src_seq[N];
  bit refill;
  bit rand_srdy;
  int max_len;

  // Scoreboard: next sequence number expected at the output per input.
  int exp_seq[N];

  // Behavioural model: owner of the channel (-1 = free), last winner, output beat.
  int           m_owner;
  int           m_last;
  bit           m_p_srdy;
  logic [W-1:0] m_p_data;
  bit           m_p_eop;
  int           m_p_grant;

  logic [N-1:0] last_drdy;

  task automatic model_reset();
    m_owner   = -1;
    m_last    = N - 1;
    m_p_srdy  = 1'b0;
    m_p_data  = '0;
    m_p_eop   = 1'b0;
    m_p_grant = 0;
    for (int i = 0; i < N; i++) exp_seq[i] = src_seq[i];
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (src_left[i] == 0 && refill) src_left[i] = int'($urandom_range(1, max_len));
      c_srdy[i] = (src_left[i] > 0) && (!rand_srdy || $urandom_range(0, 3) != 0);
      c_eop[i]  = c_srdy[i] ? (src_left[i] == 1) : 1'($urandom);
      c_data[i*W +: W] = c_srdy[i] ? {4'(i), 12'(src_seq[i])} : 16'($urandom);
    end
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    logic [N-1:0]      exp_drdy;
    logic [N-1:0]      xv;
    logic [W+GW+2:0]   exp_out;
    logic [W+GW+2:0]   got_out;
    logic [W+GW:0]     held;
    bit                stall;
    bit                ld;
    int                sel;
    int                g;
    drive_sources();
    #1;
    ld       = !m_p_srdy || p_drdy;
    sel      = -1;
    exp_drdy = '0;
    if (m_owner >= 0) begin
      if (ld) sel = m_owner;
    end else if (ld && enable) begin
      for (int k = 1; k <= N; k++)
        if (sel < 0 && c_srdy[(m_last + k) % N]) sel = (m_last + k) % N;
    end
    if (sel >= 0) exp_drdy[sel] = 1'b1;
    checks++;
    if (c_drdy !== exp_drdy) begin
      errors++;
      $display("FAIL c_drdy at %0t: got %b want %b", $time, c_drdy, exp_drdy);
    end
    last_drdy = c_drdy;
    xv = c_srdy & c_drdy;
    if (p_srdy === 1'b1 && p_drdy === 1'b1) begin
      g = int'(p_grant);
      checks++;
      if (p_data !== {4'(g), 12'(exp_seq[g])}) begin
        errors++;
        $display("FAIL payload_order at %0t: got %h want %h", $time, p_data, {4'(g), 12'(exp_seq[g])});
      end
      exp_seq[g]++;
    end
    stall = (p_srdy === 1'b1) && (p_drdy === 1'b0);
    held  = {p_eop, p_grant, p_data};
    @(posedge clock);
    if (sel >= 0 && c_srdy[sel]) begin
      m_p_srdy  = 1'b1;
      m_p_data  = c_data[sel*W +: W];
      m_p_eop   = c_eop[sel];
      m_p_grant = sel;
      if (c_eop[sel]) begin
        m_owner = -1;
        m_last  = sel;
      end else begin
        m_owner = sel;
      end
    end else if (p_drdy) begin
      m_p_srdy = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (xv[i]) begin
        src_seq[i]++;
        src_left[i]--;
      end
    #1;
    exp_out = {m_p_srdy, (m_owner >= 0), m_p_eop, GW'(m_p_grant), m_p_data};
    got_out = {p_srdy, locked, p_eop, p_grant, p_data};
    checks++;
    if (got_out !== exp_out) begin
      errors++;
      $display("FAIL outputs at %0t: got srdy/lock/eop/grant/data %h want %h", $time, got_out, exp_out);
    end
    if (stall) begin
      checks++;
      if ({p_eop, p_grant, p_data} !== held) begin
        errors++;
        $display("FAIL stall_hold at %0t: got %h want %h", $time, {p_eop, p_grant, p_data}, held);
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) src_left[i] = 0;
    refill    = 1'b0;
    rand_srdy = 1'b0;
    max_len   = 1;
    enable    = 1'b1;
    p_drdy    = 1'b1;
    drive_sources();
    @(negedge clock);
    @(negedge clock);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_drain(string tag);
    refill    = 1'b0;
    rand_srdy = 1'b0;
    enable    = 1'b1;
    p_drdy    = 1'b1;
    repeat (60) step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (src_left[i] != 0 || exp_seq[i] != src_seq[i]) begin
        errors++;
        $display("FAIL %s_drain_in%0d: got left=%0d delivered=%0d want left=0 delivered=%0d",
                 tag, i, src_left[i], exp_seq[i], src_seq[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_left[i] = 1;
      src_seq[i]  = 0;
    end
    refill    = 1'b0;
    rand_srdy = 1'b0;
    max_len   = 1;
    enable    = 1'b1;
    p_drdy    = 1'b1;
    drive_sources();
    @(negedge clock);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({p_srdy, locked, c_drdy} !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got srdy=%b locked=%b drdy=%b want all 0", c, p_srdy, locked, c_drdy);
      end
      @(negedge clock);
    end
    model_reset();
    reset = 1'b1;
    step();
    checks++;
    if (last_drdy !== 8'h01 || p_grant !== 3'd0 || p_srdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got drdy=%b grant=%0d srdy=%b want 00000001 0 1", last_drdy, p_grant, p_srdy);
    end
  endtask

  task automatic test_fairness();
    int cnt[N];
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    refill  = 1'b1;
    max_len = 1;
    for (int k = 0; k < 80; k++) begin
      step();
      checks++;
      if (p_srdy !== 1'b1 || p_grant !== GW'(k % N)) begin
        errors++;
        $display("FAIL fairness_seq beat %0d: got srdy=%b grant=%0d want 1 %0d", k, p_srdy, p_grant, k % N);
      end
      cnt[p_grant]++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 10) begin
        errors++;
        $display("FAIL fairness_count in%0d: got %0d want 10", i, cnt[i]);
      end
    end
    test_drain("fairness");
  endtask

  task automatic test_packet_lock();
    int eg[6] = '{2, 2, 2, 2, 3, 5};
    bit el[6] = '{1, 1, 1, 0, 0, 0};
    do_reset();
    src_left[2] = 4;
    src_left[3] = 1;
    src_left[5] = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (p_srdy !== 1'b1 || p_grant !== GW'(eg[k]) || locked !== el[k]) begin
        errors++;
        $display("FAIL packet_lock beat %0d: got srdy=%b grant=%0d locked=%b want 1 %0d %0d",
                 k, p_srdy, p_grant, locked, eg[k], el[k]);
      end
    end
    test_drain("lock");
  endtask

  task automatic test_backpressure();
    do_reset();
    refill  = 1'b1;
    max_len = 1;
    for (int k = 0; k < 90; k++) begin
      p_drdy = (k % 3 == 0);
      step();
    end
    test_drain("backpressure");
  endtask

  task automatic test_random();
    do_reset();
    refill    = 1'b1;
    rand_srdy = 1'b1;
    max_len   = 4;
    for (int k = 0; k < 200; k++) begin
      p_drdy = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 4) != 0);
      step();
    end
    test_drain("random");
  endtask

  task automatic test_enable_drop();
    do_reset();
    src_left[6] = 3;
    step();
    checks++;
    if (locked !== 1'b1 || p_grant !== 3'd6) begin
      errors++;
      $display("FAIL enable_beat1: got locked=%b grant=%0d want 1 6", locked, p_grant);
    end
    enable = 1'b0;
    step();
    step();
    checks++;
    if (p_srdy !== 1'b1 || p_eop !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL enable_eop_delivered: got srdy=%b eop=%b locked=%b want 1 1 0", p_srdy, p_eop, locked);
    end
    src_left[0] = 1;
    src_left[3] = 1;
    src_left[7] = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (last_drdy !== '0) begin
        errors++;
        $display("FAIL enable_hold cycle %0d: got drdy=%b want 00000000", k, last_drdy);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (last_drdy !== 8'h80 || p_grant !== 3'd7) begin
      errors++;
      $display("FAIL enable_resume: got drdy=%b grant=%0d want 10000000 7", last_drdy, p_grant);
    end
    test_drain("enable");
  endtask

  task automatic test_async_reset();
    do_reset();
    src_left[1] = 4;
    step();
    step();
    checks++;
    if (locked !== 1'b1 || p_srdy !== 1'b1) begin
      errors++;
      $display("FAIL async_precondition: got locked=%b srdy=%b want 1 1", locked, p_srdy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({locked, p_srdy, c_drdy} !== '0) begin
      errors++;
      $display("FAIL async_reset_immediate: got locked=%b srdy=%b drdy=%b want all 0", locked, p_srdy, c_drdy);
    end
    @(negedge clock);
    for (int i = 0; i < N; i++) src_left[i] = 0;
    @(negedge clock);
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) src_left[i] = 1;
    step();
    checks++;
    if (last_drdy !== 8'h01 || p_grant !== 3'd0) begin
      errors++;
      $display("FAIL async_priority: got drdy=%b grant=%0d want 00000001 0", last_drdy, p_grant);
    end
    test_drain("async");
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    p_drdy    = 1'b1;
    c_srdy    = '0;
    c_eop     = '0;
    c_data    = '0;
    last_drdy = '0;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- N-input packet arbiter that shares one output channel between requesters using round-robin.
- Sits in front of a shared destination port in the multi-arbiter fabric: one instance per destination, with all sources feeding it.
- Locks the grant for a whole multi-beat packet (held until end-of-packet); the output stage is registered.
- Inputs and output use srdy/drdy valid/ready handshakes.

Parameters:
- INPUTS, 8, number of requesters (2..16).
- WIDTH, 16, data bits per beat.
- GW, 3, grant index width, equal to clog2(INPUTS).

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous active-low reset; 0 = in reset.
- enable  in  1  1 = new packets may start; 0 = finish the current packet, then start nothing.
- c_srdy  in  INPUTS  per-input valid.
- c_drdy  out  INPUTS  per-input ready. Combinational, at most one bit high.
- c_data  in  INPUTS*WIDTH  input i occupies bits [i*WIDTH +: WIDTH].
- c_eop  in  INPUTS  per-input end-of-packet flag for the current beat.
- p_srdy  out  1  output valid.
- p_drdy  in  1  output ready.
- p_data  out  WIDTH  output beat.
- p_eop  out  1  end-of-packet flag travelling with p_data.
- p_grant  out  GW  index of the input that sourced the current p_data.
- locked  out  1  1 while the arbiter is in the LOCKED state.

Behaviour:
- Reset (reset=0, asynchronous):
  - p_srdy=0, p_data=0, p_eop=0, p_grant=0, locked=0.
  - State=IDLE.
  - Round-robin pointer last=INPUTS-1, so input 0 has top priority first.
- Load enable: ld = !p_srdy | p_drdy.
  - At most one input transfer per cycle.
  - A transfer from input i occurs when c_srdy[i] & c_drdy[i].
- State IDLE:
  - If ld & enable, select the first i with c_srdy[i]=1, scanning last+1, last+2, … mod INPUTS.
  - Assert c_drdy[i]=1 in the same cycle, so arbitration adds no bubble.
  - If the transferred beat has c_eop[i]=1: remain IDLE and set last<=i.
  - If c_eop[i]=0: go to LOCKED and set gnt<=i. last is unchanged until the packet ends.
  - If no input is requesting, or enable=0, or ld=0: all c_drdy=0 and state is unchanged.
- State LOCKED (gnt=g):
  - c_drdy[g]=ld; every other c_drdy=0.
  - enable is ignored; a packet in progress always completes.
  - On a transfer with c_eop[g]=1: go to IDLE and set last<=g.
  - No timeout: c_srdy[g]=0 simply stalls the output channel.
- Output register:
  - On a transfer: p_data<=selected c_data, p_eop<=selected c_eop, p_grant<=i, p_srdy<=1.
  - Else if p_drdy: p_srdy<=0, with data fields held.
  - Latency is 1 cycle from input transfer to p_srdy.
  - Sustained throughput is 1 beat/cycle while p_drdy=1.
- locked output mirrors the state register (1 in LOCKED).
- Simultaneous events:
  - A beat is accepted in the same cycle the previous p_data is consumed (ld through p_drdy).
  - An eop beat in LOCKED plus new requests: the next arbitration happens the following cycle, starting from last=g.
- Wrap-around: the scan wraps from INPUTS-1 to 0. With a single requester, that requester is granted every time.
- c_srdy/c_data on non-granted inputs may change freely and have no effect.
- Reset mid-packet: state returns to IDLE and the partial packet is abandoned. Upstream sources are responsible for flushing.
- Protocol assertions (simulation only):
  - $onehot0(c_drdy).
  - p_data, p_eop and p_grant remain stable while p_srdy & !p_drdy.

Test Plan:
- Reset: hold reset=0 for 10 cycles with all c_srdy=1. Required: p_srdy=0, c_drdy=0, locked=0 throughout. After reset=1, enable=1, p_drdy=1: the first grant is input 0 and p_grant=0 one cycle later.
- Fairness: all 8 inputs continuously present single-beat packets (eop=1), p_drdy=1, for 80 cycles. Required: p_grant sequence 0,1,…,7 repeating; each input gets exactly 10 beats; no idle cycles.
- Packet lock: input 2 sends a 4-beat packet (eop on beat 4) while inputs 3 and 5 request. Required: beats 1-4 are all p_grant=2 consecutively with locked=1 for 3 cycles. The next grants are 3 then 5.
- Backpressure: p_drdy toggles 1,0,0,1,… during the fairness traffic. Required: p_data stays stable while stalled; no beat is lost or duplicated; the per-input payload sequence numbers arrive in order.
- Enable drop: deassert enable during beat 2 of a 3-beat packet from input 6. Required: beat 3 (eop) is still delivered, then c_drdy=0 for all inputs until enable=1. Arbitration then resumes at input 7.
- Async reset mid-packet: assert reset=0 between clock edges while locked=1. Required: locked, p_srdy and c_drdy fall immediately without waiting for a clock edge. After release, input 0 has priority again.
